// File: rtl/pixel_scan_engine.sv
// rtl/pixel_scan_engine.sv - raster pixel generator: solid/segmented rectangle scan with start/busy/done handshake
// Optional clipping against XMAX/YMAX is enabled by defining PIXEL_SCAN_CLIP_EN.
module pixel_scan_engine #(
    parameter int XW   = 9,
    parameter int YW   = 8,
    parameter int DW   = 8,
    parameter int SCW  = 3,
    parameter int XMAX = 320,
    parameter int YMAX = 240
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [DW-1:0] w,
    input  logic [DW-1:0] h,
    input  logic [DW-1:0] seg_w,
    input  logic [DW-1:0] gap_w,
    input  logic [SCW-1:0] seg_count,
    input  logic          hold,
    output logic          busy,
    output logic          plot,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XW-1:0]  x0_q;
    logic [YW-1:0]  y0_q;
    logic [DW-1:0]  w_q;
    logic [DW-1:0]  h_q;
    logic [DW-1:0]  seg_w_q;
    logic [DW-1:0]  gap_w_q;
    logic [SCW-1:0] seg_count_q;

    logic [DW-1:0]  col_q, col_d;
    logic [DW-1:0]  row_q, row_d;
    logic [DW:0]    phase_q, phase_d;
    logic [DW-1:0]  seg_q, seg_d;

    logic           present;
    logic           lit;
    logic           plot_d;
    logic [XW-1:0]  x_d;
    logic [YW-1:0]  y_d;

    logic           accept;
    logic [DW-1:0]  w_last;
    logic [DW-1:0]  h_last;
    logic [DW:0]    period_last;
    logic [XW-1:0]  s_x0;
    logic [YW-1:0]  s_y0;
    logic [DW-1:0]  s_seg_w;
    logic [SCW-1:0] s_seg_count;

`ifdef PIXEL_SCAN_CLIP_EN
    localparam logic [XW:0] X_LIMIT = (XW+1)'(XMAX);
    localparam logic [YW:0] Y_LIMIT = (YW+1)'(YMAX);
    logic [XW:0] wide_x;
    logic [YW:0] wide_y;
`else
    localparam int UNUSED_LIMITS = XMAX + YMAX;
`endif

    assign accept      = (state_q == IDLE) && start;
    assign w_last      = w_q - DW'(1);
    assign h_last      = h_q - DW'(1);
    assign period_last = ({1'b0, seg_w_q} + {1'b0, gap_w_q}) - (DW+1)'(1);

    // The first pixel is produced on the accepting edge, before the latches update.
    assign s_x0        = (state_q == IDLE) ? x0 : x0_q;
    assign s_y0        = (state_q == IDLE) ? y0 : y0_q;
    assign s_seg_w     = (state_q == IDLE) ? seg_w : seg_w_q;
    assign s_seg_count = (state_q == IDLE) ? seg_count : seg_count_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        phase_d = phase_q;
        seg_d   = seg_q;
        present = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (w == '0 || h == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        col_d   = '0;
                        row_d   = '0;
                        phase_d = '0;
                        seg_d   = '0;
                        present = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (!hold) begin
                    if (col_q == w_last) begin
                        if (row_q == h_last) begin
                            state_d = DONE;
                        end else begin
                            col_d   = '0;
                            row_d   = row_q + 1'b1;
                            phase_d = '0;
                            seg_d   = '0;
                            present = 1'b1;
                        end
                    end else begin
                        col_d   = col_q + 1'b1;
                        present = 1'b1;
                        if (phase_q == period_last) begin
                            phase_d = '0;
                            seg_d   = seg_q + 1'b1;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lit = (s_seg_w == '0) ||
              ((phase_d < {1'b0, s_seg_w}) && (seg_d < DW'(s_seg_count)));
`ifdef PIXEL_SCAN_CLIP_EN
        wide_x = {1'b0, s_x0} + (XW+1)'(col_d);
        wide_y = {1'b0, s_y0} + (YW+1)'(row_d);
        lit    = lit && (wide_x < X_LIMIT) && (wide_y < Y_LIMIT);
`endif
        x_d    = x;
        y_d    = y;
        plot_d = 1'b0;
        if (present) begin
            x_d    = s_x0 + XW'(col_d);
            y_d    = s_y0 + YW'(row_d);
            plot_d = lit;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            phase_q     <= '0;
            seg_q       <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            seg_w_q     <= '0;
            gap_w_q     <= '0;
            seg_count_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            plot        <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            plot    <= plot_d;
            x       <= x_d;
            y       <= y_d;
            if (accept) begin
                x0_q        <= x0;
                y0_q        <= y0;
                w_q         <= w;
                h_q         <= h;
                seg_w_q     <= seg_w;
                gap_w_q     <= gap_w;
                seg_count_q <= seg_count;
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_engine.sv
// tb/tb_pixel_scan_engine.sv - self-checking bench for pixel_scan_engine
module tb_pixel_scan_engine;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [8:0] x0;
    logic [7:0] y0;
    logic [7:0] w;
    logic [7:0] h;
    logic [7:0] seg_w;
    logic [7:0] gap_w;
    logic [2:0] seg_count;
    logic       hold;
    logic       busy;
    logic       plot;
    logic [8:0] x;
    logic [7:0] y;
    logic       done;

    int checks = 0;
    int errors = 0;

    pixel_scan_engine dut (
        .clock(clock), .resetn(resetn), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h),
        .seg_w(seg_w), .gap_w(gap_w), .seg_count(seg_count),
        .hold(hold), .busy(busy), .plot(plot), .x(x), .y(y), .done(done)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        int jx0, jy0, jw, jh, jsw, jgw, jsc;
        int exp_plots;
        int exp_lat;
    } vec_t;

    // hold_mode: 0 none, 1 random, 2 three cycles while pixel 7 is presented
    task automatic run_job(input int jx0, jy0, jw, jh, jsw, jgw, jsc,
                           input int hold_mode, input int noise,
                           output int plots, output int lat);
        int ex[$];
        int ey[$];
        int ep[$];
        int total, idx, hcnt, budget, col, row, p, lt;
        bit fin;
        logic hh;
        total = jw * jh;
        p = jsw + jgw;
        for (int k = 0; k < total; k++) begin
            col = k % jw;
            row = k / jw;
            lt = (jsw == 0) ? 1 : (((col % p) < jsw) && ((col / p) < jsc));
`ifdef PIXEL_SCAN_CLIP_EN
            if (jx0 + col >= 320 || jy0 + row >= 240) lt = 0;
`endif
            ex.push_back((jx0 + col) % 512);
            ey.push_back((jy0 + row) % 256);
            ep.push_back(lt);
        end
        x0 = 9'(jx0); y0 = 8'(jy0); w = 8'(jw); h = 8'(jh);
        seg_w = 8'(jsw); gap_w = 8'(jgw); seg_count = 3'(jsc);
        hold = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1; plots = 0; idx = 0; hcnt = 0;
        budget = total + 4 * total + 20;
        if (total == 0) begin
            chk("zero_flags", {busy, done, plot}, 3'b110);
            fin = 1'b1;
        end else begin
            chk("pix_flags", {busy, done, plot}, {2'b10, 1'(ep[0])});
            chk("pix_xy", {x, y}, {9'(ex[0]), 8'(ey[0])});
            plots += int'(plot);
            fin = 1'b0;
        end
        while (!fin && lat < budget) begin
            case (hold_mode)
                1: hh = ($urandom_range(0, 3) == 0);
                2: hh = (idx == 7 && hcnt < 3);
                default: hh = 1'b0;
            endcase
            if (hh) hcnt++;
            hold = hh;
            if (noise != 0) begin
                start = 1'($urandom_range(0, 1));
                x0 = 9'($urandom); y0 = 8'($urandom); w = 8'($urandom); h = 8'($urandom);
                seg_w = 8'($urandom); gap_w = 8'($urandom); seg_count = 3'($urandom);
            end
            @(posedge clock); #1;
            lat++;
            if (hh) begin
                chk("hold_flags", {busy, done, plot}, 3'b100);
                chk("hold_xy", {x, y}, {9'(ex[idx]), 8'(ey[idx])});
            end else begin
                idx++;
                if (idx == total) begin
                    chk("done_flags", {busy, done, plot}, 3'b110);
                    fin = 1'b1;
                end else begin
                    chk("pix_flags", {busy, done, plot}, {2'b10, 1'(ep[idx])});
                    chk("pix_xy", {x, y}, {9'(ex[idx]), 8'(ey[idx])});
                end
            end
            plots += int'(plot);
        end
        hold = 1'b0;
        start = 1'b0;
        if (!fin) begin
            errors++;
            checks++;
            $display("FAIL timeout: no done after %0d cycles, required done", lat);
        end
        @(posedge clock); #1;
        chk("idle_flags", {busy, done, plot}, 3'b000);
    endtask

    vec_t vecs[$];
    int plots, lat;

    initial begin
        vecs.push_back('{10, 5, 4, 3, 0, 0, 0, 12, 13});
        vecs.push_back('{0, 0, 22, 4, 4, 2, 2, 32, 89});
        vecs.push_back('{0, 0, 22, 4, 4, 2, 4, 64, 89});
        vecs.push_back('{7, 7, 0, 5, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 2, 20, 2, 3, 0, 4, 24, 41});
        vecs.push_back('{1, 2, 10, 3, 2, 1, 0, 0, 31});
        vecs.push_back('{1, 2, 5, 2, 8, 3, 1, 10, 11});
`ifdef PIXEL_SCAN_CLIP_EN
        vecs.push_back('{318, 0, 4, 1, 0, 0, 0, 2, 5});
        vecs.push_back('{510, 0, 4, 1, 0, 0, 0, 0, 5});
`else
        vecs.push_back('{318, 0, 4, 1, 0, 0, 0, 4, 5});
        vecs.push_back('{510, 0, 4, 1, 0, 0, 0, 4, 5});
`endif

        resetn = 1'b0; start = 1'b0; hold = 1'b0;
        x0 = 9'd100; y0 = 8'd50; w = 8'd3; h = 8'd3;
        seg_w = '0; gap_w = '0; seg_count = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", {busy, done, plot, x, y}, 20'h0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_job(vecs[i].jx0, vecs[i].jy0, vecs[i].jw, vecs[i].jh, vecs[i].jsw,
                    vecs[i].jgw, vecs[i].jsc, 0, 0, plots, lat);
            chk($sformatf("vec%0d_plots", i), plots, vecs[i].exp_plots);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        run_job(0, 0, 20, 20, 0, 0, 0, 2, 1, plots, lat);
        chk("hold_plots", plots, 400);
        chk("hold_latency", lat, 404);

        x0 = 9'd3; y0 = 8'd4; w = 8'd110; h = 8'd20;
        seg_w = '0; gap_w = '0; seg_count = '0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (500) @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        chk("abort_outputs", {busy, done, plot, x, y}, 20'h0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("abort_quiet", {busy, done}, 2'b00);
        end
        run_job(0, 0, 5, 5, 0, 0, 0, 0, 0, plots, lat);
        chk("after_abort_plots", plots, 25);

        for (int r = 0; r < 30; r++) begin
            run_job(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 7)),
                    1, 1, plots, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_scan_engine.md
Name: pixel_scan_engine

Overview:
- Generic raster pixel generator for the VGA drawing path.
- Walks a runtime-sized rectangle at a runtime origin and emits one absolute (x, y) coordinate per cycle, with a plot qualifier for the framebuffer writer.
- Supports a segmented mode (repeating lit segments separated by gaps, limited segment count) for peg rows. Also covers solid squares and erase regions.
- Driven by the game controller FSM through a start/busy/done handshake. A hold input stalls the scan while the framebuffer writer is busy.

Parameters:
- XW, 9, width of x coordinate and x0 origin.
- YW, 8, width of y coordinate and y0 origin.
- DW, 8, width of dimension inputs w, h, seg_w, gap_w and of the internal column/row counters.
- SCW, 3, width of seg_count.
- XMAX, 320, screen width, used only with CLIP_EN.
- YMAX, 240, screen height, used only with CLIP_EN.

Ports:
- clock  in  1  system clock, 50 MHz
- resetn  in  1  synchronous active-low reset
- start  in  1  request a scan; sampled only in IDLE
- x0  in  XW  origin x, latched on accepted start
- y0  in  YW  origin y, latched on accepted start
- w  in  DW  rectangle width in pixels, latched
- h  in  DW  rectangle height in pixels, latched
- seg_w  in  DW  segment width; 0 = solid mode; latched
- gap_w  in  DW  gap width between segments; latched
- seg_count  in  SCW  maximum lit segments per row, segmented mode only; latched
- hold  in  1  stall; freezes scan position
- busy  out  1  high in SCAN and DONE
- plot  out  1  current x/y is a pixel to write
- x  out  XW  absolute x = x0 + col, modulo 2^XW
- y  out  YW  absolute y = y0 + row, modulo 2^YW
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; busy=0, plot=0, done=0, x=0, y=0; all counters and latched inputs cleared. Reset in any state aborts immediately and no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1 at cycle N:
  - Latch all inputs.
  - If w==0 or h==0, go to DONE at N+1.
  - Otherwise go to SCAN with col=0, row=0.
- SCAN, hold=0: outputs reflect position (col, row); advance next cycle.
  - col increments.
  - At col==w-1, col wraps to 0 and row increments.
  - At col==w-1 and row==h-1, go to DONE.
- SCAN, hold=1: col/row/phase/segment counters frozen; plot forced 0; x/y hold their values.
- Timing without hold: pixel k (raster order, k = row*w + col) is presented at cycle N+1+k. done=1 at cycle N+1+w*h, for one cycle only.
- DONE: done=1, plot=0; return to IDLE next cycle. A new start is accepted in the cycle after done.
- start while busy=1 is ignored and is not queued.
- Solid mode (seg_w==0): plot=1 at every SCAN position with hold=0.
- Segmented mode (seg_w>0):
  - Period p = seg_w + gap_w, computed at DW+1 bits.
  - Phase counter runs 0..p-1 and is reset to 0 at each row start. Segment index increments each time phase wraps.
  - plot=1 iff phase < seg_w and segment index < seg_count.
  - No divider or modulo operators are used; counters only.
- gap_w==0 in segmented mode: contiguous segments, so each row is lit for min(w, seg_w*seg_count) columns.
- seg_count==0 in segmented mode: the full scan runs with plot=0 throughout and done is still issued.
- Arithmetic: x/y additions truncate to XW/YW bits (wrap-around), with no saturation.
- Input changes after start are ignored until the next accepted start.

Optional Feature:
- Macro: PIXEL_SCAN_CLIP_EN.
- With the macro defined:
  - Sums x0+col and y0+row are formed one bit wider than XW/YW.
  - plot is suppressed when the wide x >= XMAX or the wide y >= YMAX.
  - Scan length and done timing are unchanged.
- Without the macro: no clipping; coordinates wrap modulo 2^XW / 2^YW. XMAX and YMAX are unused.

Test Plan:
- Solid mode, x0=10, y0=5, w=4, h=3, start at N:
  - Expect 12 plot pulses at N+1..N+12 with coordinates (10,5),(11,5),(12,5),(13,5),(10,6)…(13,7).
  - Expect done at N+13 and busy low at N+14.
- Segmented peg row, w=22, h=4, seg_w=4, gap_w=2, seg_count=2:
  - Expect plot on cols 0–3 and 6–9 of each row, 32 pulses total.
  - Repeat with seg_count=4: expect cols 0–3, 6–9, 12–15, 18–21, 64 pulses total.
- Zero size, w=0, h=5:
  - Expect done at N+1, no plot, busy high for exactly one cycle.
- Hold and start-while-busy, solid 20x20:
  - Assert hold for 3 cycles at k=7: expect x/y frozen, plot=0, done delayed by exactly 3 cycles, 400 plots total.
  - Pulse start mid-scan: expect it to be ignored.
- Reset mid-scan, solid 110x20:
  - Deassert resetn at k=500: expect busy/plot/done=0 and x=y=0 the next cycle, no done pulse.
  - A fresh start then completes normally.
- Clipping and wrap, x0=318, y0=0, w=4, h=1:
  - With PIXEL_SCAN_CLIP_EN: expect plot only at x=318 and x=319.
  - Without the macro: expect 4 plots at x=318, 319, 320, 321 (XW=9 does not wrap there).
  - Set x0=510: expect x to wrap to 0 and 1 after 510 and 511.
